// File: rtl/muldiv_pkg.sv
// Shared encodings for the sequential multiply/divide unit: operation codes,
// FSM state encoding and per-operation decode masks indexed by the op code.
package muldiv_pkg;

    typedef logic [2:0] muldiv_op_t;

    localparam muldiv_op_t OP_MUL    = 3'd0;
    localparam muldiv_op_t OP_MULH   = 3'd1;
    localparam muldiv_op_t OP_MULHSU = 3'd2;
    localparam muldiv_op_t OP_MULHU  = 3'd3;
    localparam muldiv_op_t OP_DIV    = 3'd4;
    localparam muldiv_op_t OP_DIVU   = 3'd5;
    localparam muldiv_op_t OP_REM    = 3'd6;
    localparam muldiv_op_t OP_REMU   = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Bit n of each mask describes op code n.
    localparam logic [7:0] OP_IS_DIV    = 8'b1111_0000;
    localparam logic [7:0] OP_IS_REM    = 8'b1100_0000;
    localparam logic [7:0] OP_MUL_HI    = 8'b0000_1110;
    localparam logic [7:0] OP_S1_SIGNED = 8'b0101_0110;
    localparam logic [7:0] OP_S2_SIGNED = 8'b0101_0010;

endpackage

// File: rtl/seq_muldiv_if.sv
// Request/response bundle of seq_muldiv; the requester uses master, the unit uses slave.
interface seq_muldiv_if #(parameter int XLEN = 32);

    logic            I_en;
    logic [2:0]      I_op;
    logic [XLEN-1:0] I_dataS1;
    logic [XLEN-1:0] I_dataS2;
    logic            O_busy;
    logic            O_valid;
    logic [XLEN-1:0] O_data;

    modport master (
        output I_en, I_op, I_dataS1, I_dataS2,
        input  O_busy, O_valid, O_data
    );

    modport slave (
        input  I_en, I_op, I_dataS1, I_dataS2,
        output O_busy, O_valid, O_data
    );

endinterface

// File: rtl/muldiv_step.sv
// One iteration on the 2*XLEN partial register: shift-add multiply (multiplier in
// the low half, shifting right) or restoring divide (dividend in the low half, shifting left).
module muldiv_step #(parameter int XLEN = 32) (
    input  logic [2*XLEN-1:0] part,
    input  logic [XLEN-1:0]   opnd,
    input  logic              is_div,
    output logic [2*XLEN-1:0] part_next
);

    logic [XLEN:0] add_sum;
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] sub_diff;

    always_comb begin
        add_sum  = {1'b0, part[2*XLEN-1:XLEN]} + (part[0] ? {1'b0, opnd} : '0);
        // Remainder stays below the divisor, so the shifted value needs one extra bit.
        rem_sh   = part[2*XLEN-1:XLEN-1];
        sub_diff = rem_sh - {1'b0, opnd};
        if (is_div) begin
            if (!sub_diff[XLEN])
                part_next = {sub_diff[XLEN-1:0], part[XLEN-2:0], 1'b1};
            else
                part_next = {rem_sh[XLEN-1:0], part[XLEN-2:0], 1'b0};
        end else begin
            part_next = {add_sum, part[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/seq_muldiv.sv
// Sequential RISC-V M multiply/divide unit, one bit per cycle on magnitudes.
// Define SEQ_MULDIV_FAST_MUL_EN to resolve multiplies in a single combinational step.
module seq_muldiv
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic        I_clk,
    input  logic        I_reset,
    seq_muldiv_if.slave bus
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(XLEN);

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [2:0]        op_r;
    logic              neg_res;
    logic              neg_rem;
    logic [2*XLEN-1:0] part;
    logic [2*XLEN-1:0] part_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   opnd;
    logic [XLEN-1:0]   fix_result;
    logic [XLEN-1:0]   dz_result;
    logic [XLEN-1:0]   s1_mag;
    logic [XLEN-1:0]   s2_mag;
    logic              accept;
    logic              op_div_in;
    logic              s1_neg;
    logic              s2_neg;
    logic              div_zero;

    function automatic logic [XLEN-1:0] cond_negate(input logic [XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_negate_w(input logic [2*XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    assign bus.O_busy  = (state == ST_CALC) || (state == ST_FIX);
    assign bus.O_valid = (state == ST_DONE);
    assign accept      = bus.I_en & ~bus.O_busy;

    assign op_div_in = OP_IS_DIV[bus.I_op];
    assign s1_neg    = OP_S1_SIGNED[bus.I_op] & bus.I_dataS1[XLEN-1];
    assign s2_neg    = OP_S2_SIGNED[bus.I_op] & bus.I_dataS2[XLEN-1];
    assign s1_mag    = cond_negate(bus.I_dataS1, s1_neg);
    assign s2_mag    = cond_negate(bus.I_dataS2, s2_neg);
    assign div_zero  = op_div_in & (bus.I_dataS2 == '0);
    assign dz_result = OP_IS_REM[bus.I_op] ? bus.I_dataS1 : '1;

`ifdef SEQ_MULDIV_FAST_MUL_EN
    logic signed [2*XLEN-1:0] fast_a;
    logic signed [2*XLEN-1:0] fast_b;
    logic signed [2*XLEN-1:0] fast_prod;
    logic [XLEN-1:0]          fast_result;

    // Low 2*XLEN bits of a wrapped product of sign/zero-extended operands are exact.
    always_comb begin
        fast_a      = {{XLEN{OP_S1_SIGNED[bus.I_op] & bus.I_dataS1[XLEN-1]}}, bus.I_dataS1};
        fast_b      = {{XLEN{OP_S2_SIGNED[bus.I_op] & bus.I_dataS2[XLEN-1]}}, bus.I_dataS2};
        fast_prod   = fast_a * fast_b;
        fast_result = OP_MUL_HI[bus.I_op] ? fast_prod[2*XLEN-1:XLEN] : fast_prod[XLEN-1:0];
    end
`endif

    muldiv_step #(.XLEN(XLEN)) u_step (
        .part      (part),
        .opnd      (opnd),
        .is_div    (OP_IS_DIV[op_r]),
        .part_next (part_next)
    );

    always_comb begin
        prod_fix = cond_negate_w(part, neg_res);
        if (OP_IS_REM[op_r])
            fix_result = cond_negate(part[2*XLEN-1:XLEN], neg_rem);
        else if (OP_IS_DIV[op_r])
            fix_result = cond_negate(part[XLEN-1:0], neg_res);
        else if (OP_MUL_HI[op_r])
            fix_result = prod_fix[2*XLEN-1:XLEN];
        else
            fix_result = prod_fix[XLEN-1:0];
    end

    // Control: FSM, step counter and result register
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bus.O_data <= '0;
        end else begin
            case (state)
                ST_CALC: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= ST_FIX;
                end
                ST_FIX: begin
                    bus.O_data <= fix_result;
                    state      <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
            if (accept) begin
                if (div_zero) begin
                    bus.O_data <= dz_result;
                    state      <= ST_DONE;
                end
`ifdef SEQ_MULDIV_FAST_MUL_EN
                else if (!op_div_in) begin
                    bus.O_data <= fast_result;
                    state      <= ST_DONE;
                end
`endif
                else begin
                    cnt   <= CNT_INIT;
                    state <= ST_CALC;
                end
            end
        end
    end

    // Datapath: operand capture at accept, one iteration per CALC cycle
    always_ff @(posedge I_clk) begin
        if (accept) begin
            op_r    <= bus.I_op;
            neg_res <= s1_neg ^ s2_neg;
            neg_rem <= s1_neg;
            if (op_div_in) begin
                part <= {{XLEN{1'b0}}, s1_mag};
                opnd <= s2_mag;
            end else begin
                part <= {{XLEN{1'b0}}, s2_mag};
                opnd <= s1_mag;
            end
        end else if (state == ST_CALC) begin
            part <= part_next;
        end
    end

endmodule
